// File: rtl/uart_pkg.sv
// uart_pkg: shared widths, queue depth default and sequencer states for the UART queues
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int DEPTH_LOG2_DEF = 4;
  typedef enum logic [1:0] {S_WAIT_IDLE, S_WAIT_BUSY, S_WAIT_DONE} tx_state_t;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous circular byte buffer with up/down occupancy counter
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_en,
  input  logic [BYTE_W-1:0]     wr_data,
  input  logic                  pop,
  output logic [BYTE_W-1:0]     head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  logic [BYTE_W-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic wr_ok, pop_ok;
  // count never exceeds the depth, so its MSB alone marks full
  assign full   = count[DEPTH_LOG2];
  assign empty  = count == '0;
  assign wr_ok  = wr_en && !full;
  assign pop_ok = pop && !empty;
  assign head   = mem[rd_ptr];
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ok ? wr_ptr + DEPTH_LOG2'(1) : wr_ptr;
      rd_ptr <= pop_ok ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
      count  <= count + {{DEPTH_LOG2{1'b0}}, wr_ok} - {{DEPTH_LOG2{1'b0}}, pop_ok};
    end
  end
  always_ff @(posedge CLK) if (wr_ok) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding uart_send one byte per full IDLE high-low-high cycle
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [BYTE_W-1:0]     WR_DATA,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  OVERFLOW,
  output logic [BYTE_W-1:0]     TX_DATA,
  output logic                  TX_DATA_READY,
  input  logic                  TX_IDLE
);
  tx_state_t state, state_d;
  logic pop;
  logic [BYTE_W-1:0] head;
  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .CLK, .RST, .wr_en(WR_EN), .wr_data(WR_DATA), .pop, .head,
    .count(COUNT), .full(FULL), .empty(EMPTY)
  );
  always_comb begin
    pop     = state == S_WAIT_IDLE && !EMPTY && TX_IDLE;
    state_d = pop ? S_WAIT_BUSY
            : (state == S_WAIT_BUSY && !TX_IDLE) ? S_WAIT_DONE
            : (state == S_WAIT_DONE && TX_IDLE) ? S_WAIT_IDLE
            : state;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= S_WAIT_IDLE;
      TX_DATA       <= '0;
      TX_DATA_READY <= 1'b0;
      OVERFLOW      <= 1'b0;
    end else begin
      state         <= state_d;
      TX_DATA       <= pop ? head : TX_DATA;
      TX_DATA_READY <= pop;
      OVERFLOW      <= OVERFLOW || (WR_EN && FULL);
    end
  end
endmodule
